usb_packet_serializer: RTL

USB_PACKET_SERIALIZER -- requirements
Module: usb_packet_serializer

---
 rtl/usb_packet_serializer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/usb_packet_serializer.sv
`default_nettype none
// ============================================================================
// Module   : usb_packet_serializer
// Function : Serialises one USB packet (SYNC, PID, token/data fields, CRC),
//            one bit per clock, with pause and payload-underrun handling.
//            Define USB_SERIALIZER_CRC_GEN_EN to append CRC5/CRC16 fields.
// Revision : 1.0 - initial release
// ============================================================================
module usb_packet_serializer #(
    parameter int MAX_BYTES = 64,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       pid,
    input  logic [6:0]       addr,
    input  logic [3:0]       endp,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             pause,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             nrz_start,
    output logic             busy,
    output logic             done,
    output logic             err_underrun
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_SYNC  = 3'd1;
    localparam logic [2:0] c_PID   = 3'd2;
    localparam logic [2:0] c_TOKEN = 3'd3;
    localparam logic [2:0] c_DATA  = 3'd4;
`ifdef USB_SERIALIZER_CRC_GEN_EN
    localparam logic [2:0] c_CRC   = 3'd5;
`endif
    localparam logic [LEN_W-1:0] c_MAX_LEN = LEN_W'(MAX_BYTES);
    localparam logic [LEN_W-1:0] c_ONE     = LEN_W'(1);

    logic [2:0]       r_state;
    logic [15:0]      r_shift;   // current field, bit_out is always r_shift[0]
    logic [3:0]       r_cnt;     // bits remaining in the field minus one
    logic [3:0]       r_pid;
    logic [6:0]       r_addr;
    logic [3:0]       r_endp;
    logic [LEN_W-1:0] r_left;    // payload bytes not yet taken

    logic w_busy;
    logic w_adv;
    logic w_field_end;
    logic w_is_token;
    logic w_is_data;
    logic w_more;
    logic w_req;
    logic w_last;

    assign w_busy      = (r_state != c_IDLE);
    assign w_adv       = w_busy && !pause && !rst;
    assign w_field_end = (r_cnt == 4'd0);
    assign w_is_token  = (r_pid[1:0] == 2'b01);
    assign w_is_data   = (r_pid[1:0] == 2'b11);
    assign w_more      = (r_left != '0);
    assign w_req       = w_adv && w_field_end && w_more &&
                         ((r_state == c_PID && w_is_data) || r_state == c_DATA);

`ifdef USB_SERIALIZER_CRC_GEN_EN
    logic [4:0]  r_crc5;
    logic [15:0] r_crc16;
    logic [4:0]  w_crc5_nxt;
    logic [15:0] w_crc16_nxt;

    // Include the bit currently on the wire so the field switch sees the full remainder
    assign w_crc5_nxt  = {r_crc5[3:0], 1'b0} ^ ((r_shift[0] ^ r_crc5[4]) ? 5'h05 : 5'h00);
    assign w_crc16_nxt = {r_crc16[14:0], 1'b0} ^
                         ((r_shift[0] ^ r_crc16[15]) ? 16'h8005 : 16'h0000);

    function automatic logic [15:0] f_rev16(input logic [15:0] v);
        logic [15:0] res;
        res = '0;
        for (int i = 0; i < 16; i++) res[i] = v[15 - i];
        return res;
    endfunction

    function automatic logic [15:0] f_rev5(input logic [4:0] v);
        logic [15:0] res;
        res = '0;
        for (int i = 0; i < 5; i++) res[i] = v[4 - i];
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc5  <= '0;
            r_crc16 <= '0;
        end else if (r_state == c_IDLE) begin
            r_crc5  <= '1;
            r_crc16 <= '1;
        end else if (w_adv) begin
            if (r_state == c_TOKEN) r_crc5 <= w_crc5_nxt;
            if (r_state == c_DATA)  r_crc16 <= w_crc16_nxt;
        end
    end
`endif

    always_comb begin
        w_last = 1'b0;
        if (w_field_end) begin
            case (r_state)
`ifdef USB_SERIALIZER_CRC_GEN_EN
                c_PID:   w_last = !w_is_token && !w_is_data;
                c_CRC:   w_last = 1'b1;
`else
                c_PID:   w_last = !w_is_token && !w_more;
                c_TOKEN: w_last = 1'b1;
                c_DATA:  w_last = !w_more;
`endif
                default: w_last = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_pid   <= '0;
            r_addr  <= '0;
            r_endp  <= '0;
            r_left  <= '0;
        end else if (r_state == c_IDLE) begin
            if (start && !pause) begin
                r_state <= c_SYNC;
                r_shift <= 16'h0080;
                r_cnt   <= 4'd7;
                r_pid   <= pid;
                r_addr  <= addr;
                r_endp  <= endp;
                r_left  <= (pid[1:0] != 2'b11) ? {LEN_W{1'b0}} :
                           (len > c_MAX_LEN)   ? c_MAX_LEN : len;
            end
        end else if (!pause) begin
            if (!w_field_end) begin
                r_shift <= r_shift >> 1;
                r_cnt   <= r_cnt - 4'd1;
            end else begin
                case (r_state)
                    c_SYNC: begin
                        r_state <= c_PID;
                        r_shift <= {8'h00, ~r_pid, r_pid};
                        r_cnt   <= 4'd7;
                    end
                    c_PID, c_DATA: begin
                        if (w_req && data_valid) begin
                            r_state <= c_DATA;
                            r_shift <= {8'h00, data_in};
                            r_cnt   <= 4'd7;
                            r_left  <= r_left - c_ONE;
                        end else if (w_req) begin
                            r_state <= c_IDLE;
                            r_shift <= '0;
                            r_cnt   <= '0;
                        end else if (r_state == c_PID && w_is_token) begin
                            r_state <= c_TOKEN;
                            r_shift <= {5'b0, r_endp, r_addr};
                            r_cnt   <= 4'd10;
`ifdef USB_SERIALIZER_CRC_GEN_EN
                        end else if (w_is_data) begin
                            // Zero-length DATA still carries the CRC of the empty payload
                            r_state <= c_CRC;
                            r_shift <= f_rev16((r_state == c_PID) ? ~r_crc16 : ~w_crc16_nxt);
                            r_cnt   <= 4'd15;
`endif
                        end else begin
                            r_state <= c_IDLE;
                            r_shift <= '0;
                            r_cnt   <= '0;
                        end
                    end
`ifdef USB_SERIALIZER_CRC_GEN_EN
                    c_TOKEN: begin
                        r_state <= c_CRC;
                        r_shift <= f_rev5(~w_crc5_nxt);
                        r_cnt   <= 4'd4;
                    end
`endif
                    default: begin
                        r_state <= c_IDLE;
                        r_shift <= '0;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign bit_out      = w_busy && !rst && r_shift[0];
    assign bit_valid    = w_adv;
    assign busy         = w_busy && !rst;
    assign nrz_start    = (r_state == c_IDLE) && start && !pause && !rst;
    assign done         = w_adv && w_last;
    assign data_ready   = w_req;
    assign err_underrun = w_req && !data_valid;

endmodule
`default_nettype wire
